dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_array.sv | 30 +++
 rtl/dmem_responder.sv | 116 +++++++++++
 tb/tb_dmem_responder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types and constants for the data-memory responder: FSM states,
// bus widths and the access-fault classification.
package dmem_pkg;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;
   localparam int BE_W   = DATA_W / 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Fault codes are one-hot so both causes can be reported together.
   localparam logic [1:0] ERR_NONE         = 2'b00;
   localparam logic [1:0] ERR_MISALIGNED   = 2'b01;
   localparam logic [1:0] ERR_OUT_OF_RANGE = 2'b10;

   function automatic logic [1:0] access_error(input logic [ADDR_W-1:0] addr,
                                               input int depth);
      logic [1:0] code;
      code = ERR_NONE;
      if (addr[1:0] != 2'b00)
         code = code | ERR_MISALIGNED;
      if ({2'b00, addr[ADDR_W-1:2]} >= $unsigned(depth))
         code = code | ERR_OUT_OF_RANGE;
      return code;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised storage: byte-enabled synchronous write, combinational read.
// Contents are intentionally never reset.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
   input  logic              clk,
   input  logic              we,
   input  logic [BE_W-1:0]   be,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH_WORDS];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int i = 0; i < BE_W; i++) begin
            if (be[i])
               mem[addr][8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with a configurable number of
// wait states between request acceptance and the storage access.
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [BE_W-1:0]   req_be,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   state_t            state, state_next;
   logic [3:0]        wait_cnt;
   logic              write_q;
   logic [ADDR_W-1:0] addr_q;
   logic [BE_W-1:0]   be_q;
   logic [DATA_W-1:0] wdata_q;
   logic [DATA_W-1:0] rdata_q;
   logic              err_q;
   logic [DATA_W-1:0] mem_rdata;
   logic              accept;
   logic              access;
   logic              access_err;
   logic              mem_we;

   always_ff @(posedge clk) begin
      if (!reset)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      accept     = 1'b0;
      access     = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               accept     = 1'b1;
               state_next = WAIT;
            end
         end
         WAIT: begin
            if (wait_cnt == 4'd0) begin
               access     = 1'b1;
               state_next = RESP;
            end
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // The fault check uses only the latched address, so bus activity during
   // WAIT/RESP cannot disturb the access in flight.
   assign access_err = (access_error(addr_q, DEPTH_WORDS) != ERR_NONE);
   assign mem_we     = access && write_q && !access_err && reset;

   always_ff @(posedge clk) begin
      if (!reset) begin
         wait_cnt <= 4'd0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
      end else begin
         if (accept) begin
            write_q  <= req_write;
            addr_q   <= req_addr;
            be_q     <= req_be;
            wdata_q  <= req_wdata;
            wait_cnt <= 4'(WAIT_STATES);
         end else if (state == WAIT && wait_cnt != 4'd0) begin
            wait_cnt <= wait_cnt - 4'd1;
         end
         if (access) begin
            err_q   <= access_err;
            rdata_q <= (access_err || write_q) ? '0 : mem_rdata;
         end
      end
   end

   dmem_array #(
      .DEPTH_WORDS(DEPTH_WORDS)
   ) u_array (
      .clk  (clk),
      .we   (mem_we),
      .be   (be_q),
      .addr (addr_q[AW+1:2]),
      .wdata(wdata_q),
      .rdata(mem_rdata)
   );

   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset corner
// cases, a zero-wait-state instance and randomized traffic against a word model.
module tb_dmem_responder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;

   logic        req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic [3:0]  req_be = '0;
   logic        req_ready, resp_valid, resp_err;
   logic [31:0] resp_rdata;

   logic        req_valid0 = 1'b0, req_write0 = 1'b0, resp_ready0 = 1'b0;
   logic [31:0] req_addr0 = '0, req_wdata0 = '0;
   logic [3:0]  req_be0 = '0;
   logic        req_ready0, resp_valid0, resp_err0;
   logic [31:0] resp_rdata0;

   int total = 0;
   int bad   = 0;

   logic [31:0] model [256];

   typedef struct {
      logic        w;
      logic [31:0] a;
      logic [3:0]  be;
      logic [31:0] d;
      int          hold;
      logic [31:0] exp_rd;
      logic        exp_err;
   } vec_t;

   vec_t vecs [11];

   always #5 clk = ~clk;

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(2)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err)
   );

   dmem_responder #(.DEPTH_WORDS(256), .WAIT_STATES(0)) dut0 (
      .clk(clk), .reset(reset),
      .req_valid(req_valid0), .req_ready(req_ready0), .req_write(req_write0),
      .req_addr(req_addr0), .req_be(req_be0), .req_wdata(req_wdata0),
      .resp_valid(resp_valid0), .resp_ready(resp_ready0),
      .resp_rdata(resp_rdata0), .resp_err(resp_err0)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++)
         if (be[i]) r[8*i +: 8] = d[8*i +: 8];
      return r;
   endfunction

   // One full transaction on the W=2 instance, checked against the word model.
   task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [3:0] b,
                                input logic [31:0] d, input int hold,
                                output logic [31:0] rd, output logic er);
      logic        exp_err;
      logic [31:0] exp_rd;
      int          lat;
      int          guard;
      exp_err = (a[1:0] != 2'b00) || (a >= 32'h400);
      exp_rd  = (exp_err || w) ? 32'h0 : model[a[9:2]];
      rd = '0;
      er = 1'b0;
      @(negedge clk);
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge clk);
         guard++;
      end
      if (!req_ready) begin
         checkOutput("ready_timeout", 32'(req_ready), 32'd1);
         return;
      end
      req_valid = 1'b1; req_write = w; req_addr = a; req_be = b; req_wdata = d;
      resp_ready = 1'b0;
      @(posedge clk); #1;
      req_write = 1'($urandom); req_addr = $urandom; req_be = 4'($urandom); req_wdata = $urandom;
      lat = 0;
      do begin
         @(posedge clk); #1;
         lat++;
      end while (!resp_valid && lat < 40);
      checkOutput("latency", 32'(lat), 32'd3);
      if (!resp_valid) begin
         req_valid = 1'b0;
         return;
      end
      rd = resp_rdata;
      er = resp_err;
      checkOutput("rdata", rd, exp_rd);
      checkOutput("err", 32'(er), 32'(exp_err));
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         checkOutput("hold_valid", 32'(resp_valid), 32'd1);
         checkOutput("hold_rdata", resp_rdata, exp_rd);
         checkOutput("hold_err", 32'(resp_err), 32'(exp_err));
         checkOutput("hold_req_ready", 32'(req_ready), 32'd0);
      end
      @(negedge clk);
      req_valid = 1'b0;
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0;
      checkOutput("release_valid", 32'(resp_valid), 32'd0);
      checkOutput("release_req_ready", 32'(req_ready), 32'd1);
      if (!exp_err && w)
         model[a[9:2]] = merge(model[a[9:2]], d, b);
   endtask

   initial begin
      logic [31:0] rd;
      logic        er;
      logic [31:0] a;
      logic [31:0] old20;
      int          r;

      vecs[0]  = '{1'b1, 32'h10,  4'hF, 32'hDEADBEEF, 0, 32'h0,        1'b0};
      vecs[1]  = '{1'b0, 32'h10,  4'h0, 32'h0,        0, 32'hDEADBEEF, 1'b0};
      vecs[2]  = '{1'b1, 32'h10,  4'h2, 32'h0000AA00, 0, 32'h0,        1'b0};
      vecs[3]  = '{1'b0, 32'h10,  4'hF, 32'h0,        5, 32'hDEADAAEF, 1'b0};
      vecs[4]  = '{1'b0, 32'h13,  4'hF, 32'h0,        0, 32'h0,        1'b1};
      vecs[5]  = '{1'b0, 32'h400, 4'hF, 32'h0,        0, 32'h0,        1'b1};
      vecs[6]  = '{1'b1, 32'h400, 4'hF, 32'hFFFFFFFF, 0, 32'h0,        1'b1};
      vecs[7]  = '{1'b1, 32'h10,  4'h0, 32'h11111111, 0, 32'h0,        1'b0};
      vecs[8]  = '{1'b0, 32'h10,  4'h0, 32'h0,        2, 32'hDEADAAEF, 1'b0};
      vecs[9]  = '{1'b1, 32'h3FC, 4'hF, 32'h0BADF00D, 0, 32'h0,        1'b0};
      vecs[10] = '{1'b0, 32'h3FC, 4'h0, 32'h0,        0, 32'h0BADF00D, 1'b0};

      for (int i = 0; i < 256; i++) model[i] = '0;

      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_req_ready", 32'(req_ready), 32'd1);
      checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("reset_resp_err", 32'(resp_err), 32'd0);
      checkOutput("reset_resp_rdata", resp_rdata, 32'h0);
      @(negedge clk);
      reset = 1'b1;

      // Zero-wait-state instance: response one edge after acceptance.
      @(negedge clk);
      req_valid0 = 1'b1; req_write0 = 1'b1; req_addr0 = 32'h8; req_be0 = 4'hF; req_wdata0 = 32'hCAFEF00D;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      checkOutput("w0_store_not_early", 32'(resp_valid0), 32'd0);
      @(posedge clk); #1;
      checkOutput("w0_store_valid", 32'(resp_valid0), 32'd1);
      @(negedge clk); resp_ready0 = 1'b1;
      @(posedge clk); #1; resp_ready0 = 1'b0;
      @(negedge clk);
      req_valid0 = 1'b1; req_write0 = 1'b0; req_addr0 = 32'h8;
      @(posedge clk); #1;
      req_valid0 = 1'b0;
      @(posedge clk); #1;
      checkOutput("w0_load_valid", 32'(resp_valid0), 32'd1);
      checkOutput("w0_load_rdata", resp_rdata0, 32'hCAFEF00D);
      checkOutput("w0_load_err", 32'(resp_err0), 32'd0);
      @(negedge clk); resp_ready0 = 1'b1;
      @(posedge clk); #1; resp_ready0 = 1'b0;

      for (int i = 0; i < 256; i++)
         applyStimulus(1'b1, 32'(i) << 2, 4'hF, 32'(i) * 32'h01010101 ^ 32'hA5A5_5A5A, 0, rd, er);

      for (int i = 0; i < 11; i++) begin
         applyStimulus(vecs[i].w, vecs[i].a, vecs[i].be, vecs[i].d, vecs[i].hold, rd, er);
         checkOutput($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rd);
         checkOutput($sformatf("vec%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
      end

      for (int i = 0; i < 256; i++)
         applyStimulus(1'b0, 32'(i) << 2, 4'h0, 32'h0, 0, rd, er);

      // Reset in the middle of WAIT must abort a store to 0x20.
      old20 = model[8];
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h20; req_be = 4'hF; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("abort_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("abort_req_ready", 32'(req_ready), 32'd1);
      checkOutput("abort_resp_rdata", resp_rdata, 32'h0);
      @(negedge clk); reset = 1'b1;
      applyStimulus(1'b0, 32'h20, 4'hF, 32'h0, 0, rd, er);
      checkOutput("abort_old_value", rd, old20);

      // Reset while a response is pending drops it.
      @(negedge clk);
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("drop_pre_valid", 32'(resp_valid), 32'd1);
      @(negedge clk); reset = 1'b0;
      @(posedge clk); #1;
      checkOutput("drop_resp_valid", 32'(resp_valid), 32'd0);
      checkOutput("drop_resp_err", 32'(resp_err), 32'd0);
      @(negedge clk); reset = 1'b1;

      for (int n = 0; n < 150; n++) begin
         r = $urandom_range(0, 9);
         if (r == 0)
            a = (32'($urandom_range(0, 255)) << 2) | 32'($urandom_range(1, 3));
         else if (r == 1)
            a = 32'($urandom_range(256, 4095)) << 2;
         else
            a = 32'($urandom_range(0, 255)) << 2;
         applyStimulus(1'($urandom), a, 4'($urandom), $urandom, $urandom_range(0, 3), rd, er);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
